ila_core: RTL and testbench
===========================

# ila_core

Parametrised integrated logic analyzer core, the capture engine behind the `R_ILA_*` register window at base `0xf810_0000`. It samples a probe vector into a circular sample RAM every clock and detects a masked-compare trigger. After the trigger it records a programmable number of post-trigger samples, then freezes. The bus reads back info, status, trigger index and the RAM, 32 bits per access.

## Interface
- `SAMPLE_W`, 32: probe width, 1..32.
- `DEPTH`, 1024: sample RAM entries; must be a power of two, 2..65536.
- `AW`, 16: byte-address width of the bus window. Must satisfy 2^AW >= 0x1000 + 4*DEPTH.
- `clk`  in  1  sole clock; probe, bus and RAM are all synchronous to it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `probe`  in  SAMPLE_W  signals under observation.
- `bus_sel`  in  1  access request; held high until `bus_ready`.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  AW  byte offset from `R_ILA_BASE`; bits [1:0] ignored.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data, valid while `bus_ready` = 1.
- `bus_ready`  out  1  single-cycle completion pulse.

## Operation
- Register offsets:
  - 0x00 INFO (RO): [7:0] = SAMPLE_W, [12:8] = log2(DEPTH).
  - 0x04 CTRL (WO, self-clearing): bit0 = start, bit1 = stop.
  - 0x08 STATUS (RO): bit0 = running, bit1 = triggered, bit2 = done.
  - 0x0C TRIG_POST_SAMPLES (RW): width log2(DEPTH), reset DEPTH/2.
  - 0x10 TRIG_IDX (RO): RAM index holding the trigger sample.
  - 0x14 TRIG_MASK (RW): width SAMPLE_W, reset 0.
  - 0x18 TRIG_VALUE (RW): width SAMPLE_W, reset 0.
  - 0x1000 + 4*i: RAM entry i, zero-extended to 32 bits.
  - Unmapped offsets read 0; writes to them and to RO registers are ignored.
- Trigger condition: `(probe & TRIG_MASK) == (TRIG_VALUE & TRIG_MASK)`. A mask of 0 triggers on the first armed cycle.
- Write pointer `wp`: log2(DEPTH) bits, wraps DEPTH-1 -> 0 with no flag.
- FSM states:
  - IDLE: no capture.
  - ARMED: every cycle, write `probe` to RAM[wp] and increment `wp`. When the trigger condition holds, the same cycle's sample is written, TRIG_IDX <= wp, triggered <= 1, post counter <= TRIG_POST_SAMPLES, then:
    - counter = 0 -> DONE;
    - otherwise -> POST.
  - POST: write and increment `wp`, decrement the counter; on the cycle the counter goes 1 -> 0 (last sample written) -> DONE.
  - DONE: no capture; RAM frozen.
- Start (any state): `wp` <= 0, triggered <= 0, -> ARMED.
- Stop (any state): -> IDLE; TRIG_IDX, triggered and RAM are kept.
- Start and stop in the same write: stop wins.
- STATUS bits: running = 1 in ARMED or POST; done = 1 in DONE.
- TRIG_POST_SAMPLES is sampled at trigger time. Writes during POST do not affect the capture in progress.
- RAM reads while running return 0, because the port is owned by capture. Host reads in IDLE or DONE use the same single RAM port.
- Trigger in the first armed cycle: pre-trigger samples are stale contents from earlier captures. There is no valid-count register; software uses TRIG_IDX and TRIG_POST_SAMPLES.

## Timing
- Reset values: state IDLE, `wp` 0, TRIG_IDX 0, triggered 0, `bus_ready` 0, `bus_rdata` 0, registers as listed above. RAM contents are undefined.
- Bus access: `bus_sel` rises at cycle T; `bus_ready` pulses and `bus_rdata` is valid at T+1 for every address, register or RAM. A new access may start at T+2.
- Writes take effect at the T+1 edge. A start written in cycle T has its first sample captured in cycle T+1.
- Probe sample captured in cycle N is in RAM at the N+1 edge.
- Trigger evaluation uses the raw probe with no pipeline. Triggered/done are visible in STATUS the cycle after the transition edge.
- `rst_n` asserted mid-capture returns to IDLE immediately (asynchronous) and aborts any bus access in flight: no `bus_ready`.

## Test plan
- Reset, then read INFO -> 0x0000_0A20 with SAMPLE_W=32, DEPTH=1024; STATUS -> 0; TRIG_POST_SAMPLES -> 512.
- Probe = counter from 0, mask 0xFFFF_FFFF, value 100, post 10, start -> TRIG_IDX = 100, done after 10 more cycles. RAM[100] = 100, RAM[110] = 110, RAM[111] holds stale data.
- Mask 0, post 0, start -> done 2 cycles after the start write; TRIG_IDX = 0; RAM[0] = probe value at the first armed cycle.
- Trigger at value 2000 with DEPTH=1024, post 50 -> wrap covered: TRIG_IDX = 2000 mod 1024 = 976; RAM[1023] and RAM[0..2] contiguous; done with `wp` = 3.
- Stop during ARMED -> STATUS 0, triggered 0. Start and stop in one write -> IDLE. Start during DONE -> re-armed with triggered cleared.
- Assert `rst_n` during POST with a RAM read pending -> STATUS 0 after release and no `bus_ready` pulse. RAM read while ARMED -> 0.

Source files
------------

// File: rtl/ila_core.sv
// Integrated logic analyzer capture engine: circular sample RAM, masked-compare
// trigger, programmable post-trigger depth and a 32-bit register/RAM bus window.
module ila_core #(
    parameter int SAMPLE_W = 32,
    parameter int DEPTH    = 1024,
    parameter int AW       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] probe,
    input  logic                bus_sel,
    input  logic                bus_we,
    input  logic [AW-1:0]       bus_addr,
    input  logic [31:0]         bus_wdata,
    output logic [31:0]         bus_rdata,
    output logic                bus_ready
);

    localparam int AB = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        POST,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [SAMPLE_W-1:0] ram [DEPTH];
    logic [SAMPLE_W-1:0] ram_rd_q;
    logic                rd_ram_q;
    logic [31:0]         reg_rd_q;

    logic [AB-1:0]       wp_q;
    logic [AB-1:0]       trig_idx_q;
    logic [AB-1:0]       post_cnt_q;
    logic [AB-1:0]       post_samples_q;
    logic                triggered_q;
    logic [SAMPLE_W-1:0] trig_mask_q;
    logic [SAMPLE_W-1:0] trig_value_q;

    logic        access, wr, rd;
    logic [31:0] byte_addr, ram_off;
    logic        ram_hit;
    logic [AB-1:0] ram_idx;
    logic        start, stop;
    logic        running, trig_hit;
    logic        capture, trig_fire;
    logic [31:0] reg_mux;

    // bus_sel stays high through the ready cycle; only its first cycle is an access
    assign access    = bus_sel && !bus_ready;
    assign wr        = access && bus_we;
    assign rd        = access && !bus_we;
    assign byte_addr = 32'(bus_addr) & 32'hFFFF_FFFC;
    assign ram_off   = byte_addr - 32'h0000_1000;
    assign ram_hit   = (byte_addr >= 32'h0000_1000) && (ram_off < 32'(4 * DEPTH));
    assign ram_idx   = ram_off[AB+1:2];

    assign start    = wr && (byte_addr == 32'h04) && bus_wdata[0] && !bus_wdata[1];
    assign stop     = wr && (byte_addr == 32'h04) && bus_wdata[1];
    assign running  = (state_q == ARMED) || (state_q == POST);
    assign trig_hit = ((probe & trig_mask_q) == (trig_value_q & trig_mask_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        trig_fire = 1'b0;
        case (state_q)
            ARMED: begin
                capture = 1'b1;
                if (trig_hit) begin
                    trig_fire = 1'b1;
                    state_d   = (post_samples_q == '0) ? DONE : POST;
                end
            end
            POST: begin
                capture = 1'b1;
                if (post_cnt_q == AB'(1)) begin
                    state_d = DONE;
                end
            end
            default: ;
        endcase
        // A control write overrides whatever capture would have done this cycle
        if (start || stop) begin
            capture   = 1'b0;
            trig_fire = 1'b0;
            state_d   = stop ? IDLE : ARMED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            trig_idx_q  <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
        end else if (start) begin
            wp_q        <= '0;
            triggered_q <= 1'b0;
        end else if (capture) begin
            wp_q <= wp_q + AB'(1);
            if (trig_fire) begin
                trig_idx_q  <= wp_q;
                triggered_q <= 1'b1;
                post_cnt_q  <= post_samples_q;
            end else if (state_q == POST) begin
                post_cnt_q <= post_cnt_q - AB'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_samples_q <= AB'(DEPTH / 2);
            trig_mask_q    <= '0;
            trig_value_q   <= '0;
        end else if (wr) begin
            case (byte_addr)
                32'h0C:  post_samples_q <= bus_wdata[AB-1:0];
                32'h14:  trig_mask_q    <= bus_wdata[SAMPLE_W-1:0];
                32'h18:  trig_value_q   <= bus_wdata[SAMPLE_W-1:0];
                default: ;
            endcase
        end
    end

    // Single RAM port: capture owns it while running, the host otherwise
    always_ff @(posedge clk) begin
        if (capture) begin
            ram[wp_q] <= probe;
        end
        if (rd && ram_hit && !running) begin
            ram_rd_q <= ram[ram_idx];
        end
    end

    always_comb begin
        reg_mux = '0;
        case (byte_addr)
            32'h00:  reg_mux = {19'b0, 5'(AB), 8'(SAMPLE_W)};
            32'h08:  reg_mux = {29'b0, (state_q == DONE), triggered_q, running};
            32'h0C:  reg_mux = 32'(post_samples_q);
            32'h10:  reg_mux = 32'(trig_idx_q);
            32'h14:  reg_mux = 32'(trig_mask_q);
            32'h18:  reg_mux = 32'(trig_value_q);
            default: reg_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ready <= 1'b0;
            rd_ram_q  <= 1'b0;
            reg_rd_q  <= '0;
        end else begin
            bus_ready <= access;
            if (access) begin
                rd_ram_q <= rd && ram_hit && !running;
                reg_rd_q <= rd ? reg_mux : '0;
            end
        end
    end

    assign bus_rdata = rd_ram_q ? 32'(ram_rd_q) : reg_rd_q;

endmodule

// File: tb/tb_ila_core.sv
// Self-checking bench for ila_core: bus reads push expected values to a
// scoreboard queue; each test pops and compares once its reads are done.
module tb_ila_core;

    localparam int SAMPLE_W = 32;
    localparam int DEPTH    = 1024;
    localparam int AW       = 16;

    logic                clk;
    logic                rst_n;
    logic [SAMPLE_W-1:0] probe;
    logic                bus_sel;
    logic                bus_we;
    logic [AW-1:0]       bus_addr;
    logic [31:0]         bus_wdata;
    logic [31:0]         bus_rdata;
    logic                bus_ready;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] act_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] probe_base = '0;
    logic        restart_tog = 1'b0;

    ila_core #(
        .SAMPLE_W(SAMPLE_W),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .probe    (probe),
        .bus_sel  (bus_sel),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Probe counts up every cycle; a restart request reloads it with probe_base
    initial begin
        logic seen_tog;
        seen_tog = 1'b0;
        probe    = '0;
        forever begin
            @(posedge clk);
            #2;
            if (restart_tog != seen_tog) begin
                seen_tog = restart_tog;
                probe    = probe_base;
            end else begin
                probe = probe + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic logic [AW-1:0] ram_a(input int i);
        return AW'(32'h1000 + 4 * i);
    endfunction

    // Called at posedge+1; returns at posedge+1 two cycles later
    task automatic bus_xfer(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                            input logic restart, output logic [31:0] d);
        bus_sel   = 1'b1;
        bus_we    = we;
        bus_addr  = a;
        bus_wdata = wd;
        @(posedge clk);
        #1;
        if (restart) restart_tog = ~restart_tog;
        d = (bus_ready === 1'b1) ? bus_rdata : 'x;
        bus_sel = 1'b0;
        bus_we  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] wd, input logic restart);
        logic [31:0] d;
        bus_xfer(1'b1, a, wd, restart, d);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] e, input string n);
        logic [31:0] d;
        exp_q.push_back('{name: n, val: e});
        bus_xfer(1'b0, a, '0, 1'b0, d);
        act_q.push_back(d);
    endtask

    task automatic test_reset;
        exp_t        e;
        logic [31:0] a;
        rst_n     = 1'b0;
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_ready !== 1'b0 || bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rdata=%h, expected ready=0 rdata=0", bus_ready, bus_rdata);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(16'h00, 32'h0000_0A20, "info");
        rd(16'h08, 32'h0, "status_reset");
        rd(16'h0C, 32'd512, "post_reset");
        rd(16'h10, 32'h0, "trig_idx_reset");
        rd(16'h14, 32'h0, "mask_reset");
        rd(16'h18, 32'h0, "value_reset");
        rd(16'h04, 32'h0, "ctrl_wo");
        rd(16'h1C, 32'h0, "unmapped");
        wr(16'h00, 32'hFFFF_FFFF, 1'b0);
        rd(16'h00, 32'h0000_0A20, "info_ro");
        wr(16'h0C, 32'd7, 1'b0);
        rd(16'h0C, 32'd7, "post_rw");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_wrap;
        exp_t        e;
        logic [31:0] a;
        probe_base = 32'd0;
        wr(16'h14, 32'hFFFF_FFFF, 1'b0);
        wr(16'h18, 32'd2000, 1'b0);
        wr(16'h0C, 32'd50, 1'b0);
        wr(16'h04, 32'h1, 1'b1);
        repeat (2060) @(posedge clk);
        #1;
        rd(16'h08, 32'h6, "wrap_status_done");
        rd(16'h10, 32'd976, "wrap_trig_idx");
        rd(ram_a(976), 32'd2000, "wrap_ram976");
        rd(ram_a(1023), 32'd2047, "wrap_ram1023");
        rd(ram_a(0), 32'd2048, "wrap_ram0");
        rd(ram_a(2), 32'd2050, "wrap_ram2");
        rd(ram_a(3), 32'd1027, "wrap_ram3_stale");
        rd(ram_a(1024), 32'h0, "ram_past_end");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_trigger;
        exp_t        e;
        logic [31:0] a;
        probe_base = 32'd0;
        wr(16'h18, 32'd100, 1'b0);
        wr(16'h0C, 32'd10, 1'b0);
        wr(16'h04, 32'h1, 1'b1);
        repeat (103) @(posedge clk);
        #1;
        wr(16'h0C, 32'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rd(16'h08, 32'h3, "trig_status_post");
        rd(16'h08, 32'h6, "trig_status_done");
        rd(16'h10, 32'd100, "trig_idx");
        rd(ram_a(100), 32'd100, "trig_ram100");
        rd(ram_a(110), 32'd110, "trig_ram110");
        rd(ram_a(111), 32'd1135, "trig_ram111_stale");
        rd(16'h0C, 32'd3, "post_written_in_post");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_mask_zero;
        exp_t        e;
        logic [31:0] a;
        probe_base = 32'hA5A5_0000;
        wr(16'h14, 32'h0, 1'b0);
        wr(16'h0C, 32'h0, 1'b0);
        wr(16'h04, 32'h1, 1'b1);
        rd(16'h08, 32'h6, "mask0_status_done");
        rd(16'h10, 32'h0, "mask0_trig_idx");
        rd(ram_a(0), 32'hA5A5_0000, "mask0_ram0");
        rd(ram_a(1), 32'd1, "mask0_ram1_stale");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_stop_restart;
        exp_t        e;
        logic [31:0] a;
        wr(16'h14, 32'hFFFF_FFFF, 1'b0);
        wr(16'h18, 32'hFFFF_FFFF, 1'b0);
        wr(16'h04, 32'h1, 1'b0);
        rd(16'h08, 32'h1, "rearm_from_done");
        rd(ram_a(5), 32'h0, "ram_read_armed");
        wr(16'h04, 32'h2, 1'b0);
        rd(16'h08, 32'h0, "stop_armed");
        wr(16'h04, 32'h1, 1'b0);
        rd(16'h08, 32'h1, "start_again");
        wr(16'h04, 32'h3, 1'b0);
        rd(16'h08, 32'h0, "start_stop_same");
        wr(16'h14, 32'h0, 1'b0);
        wr(16'h04, 32'h1, 1'b0);
        rd(16'h08, 32'h6, "done_again");
        wr(16'h04, 32'h2, 1'b0);
        rd(16'h08, 32'h2, "stop_keeps_triggered");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t        e;
        logic [31:0] a;
        wr(16'h0C, 32'd1000, 1'b0);
        wr(16'h04, 32'h1, 1'b0);
        rd(16'h08, 32'h3, "mid_status_post");
        bus_sel  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = ram_a(10);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready: got %b, expected 0", bus_ready);
        end
        bus_sel = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready_late: got %b, expected 0", bus_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(16'h08, 32'h0, "mid_status_after");
        rd(16'h0C, 32'd512, "mid_post_after");
        rd(16'h14, 32'h0, "mid_mask_after");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_trigger();
        test_mask_zero();
        test_stop_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
